// File: rtl/vga_sprite_writer.sv
// Uploads the shadow sprite bitmaps and positions into the display register file,
// one 3-cycle register write at a time, once per synchronized IRQ_Vsync rising edge.
module vga_sprite_writer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_50_mhz,
  input  logic        rst,
  input  logic        IRQ_Vsync,
  input  logic [9:0]  ship_x,
  input  logic [9:0]  ship_y,
  input  logic [9:0]  planet_x,
  input  logic [9:0]  planet_y,
  input  logic        pos_valid,
  input  logic        bmp_we,
  input  logic        bmp_sel,
  input  logic [3:0]  bmp_row,
  input  logic [15:0] bmp_data,
  output logic        wren,
  output logic [5:0]  addr,
  output logic [15:0] ldr,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [5:0] IDX_SHIP0     = 6'd0;
  localparam logic [5:0] IDX_SHIP_LAST = 6'd15;
  localparam logic [5:0] IDX_PLANET0   = 6'd16;
  localparam logic [5:0] IDX_POS0      = 6'd32;
  localparam logic [5:0] IDX_LAST      = 6'd35;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_q;
  logic                   r_rise;
  logic [15:0]            r_ship   [16];
  logic [15:0]            r_planet [16];
  logic [9:0]             r_pend   [4];
  logic [9:0]             r_snap   [4];
  logic [9:0]             w_pos_in [4];
  logic [9:0]             w_pend_nxt [4];
  logic [9:0]             w_snap_nxt [4];
  logic                   r_dirty_ship;
  logic                   r_dirty_planet;
  logic [5:0]             r_idx;
  logic [5:0]             w_idx_nxt;
  logic [15:0]            r_ldr;
  logic [15:0]            w_ldr_nxt;
  logic                   w_load;
  logic                   w_start;

  always_ff @(posedge clk_50_mhz) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rise) begin
          w_state_nxt = S_SETUP;
          w_load      = 1'b1;
          w_start     = 1'b1;
          w_idx_nxt   = r_dirty_ship ? IDX_SHIP0 : (r_dirty_planet ? IDX_PLANET0 : IDX_POS0);
        end
      end
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (r_idx == IDX_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SETUP;
          w_load      = 1'b1;
          if (r_idx == IDX_SHIP_LAST) w_idx_nxt = r_dirty_planet ? IDX_PLANET0 : IDX_POS0;
          else                        w_idx_nxt = r_idx + 6'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pos_valid in the same cycle as the snapshot feeds the snapshot directly.
  always_comb begin
    w_pos_in[0] = ship_x;
    w_pos_in[1] = ship_y;
    w_pos_in[2] = planet_x;
    w_pos_in[3] = planet_y;
    for (int i = 0; i < 4; i++) begin
      w_pend_nxt[i] = pos_valid ? w_pos_in[i] : r_pend[i];
      w_snap_nxt[i] = w_start ? w_pend_nxt[i] : r_snap[i];
    end
  end

  always_comb begin
    if (w_idx_nxt[5])      w_ldr_nxt = {6'b0, w_snap_nxt[w_idx_nxt[1:0]]};
    else if (w_idx_nxt[4]) w_ldr_nxt = r_planet[w_idx_nxt[3:0]];
    else                   w_ldr_nxt = r_ship[w_idx_nxt[3:0]];
  end

  always_ff @(posedge clk_50_mhz) begin
    if (rst) begin
      // NOTE: the shadow rows are cleared by reset, which keeps them in flops rather than a RAM macro.
      for (int i = 0; i < 16; i++) begin
        r_ship[i]   <= '0;
        r_planet[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        r_pend[i] <= '0;
        r_snap[i] <= '0;
      end
      r_sync         <= '0;
      r_sync_q       <= 1'b0;
      r_rise         <= 1'b0;
      r_idx          <= '0;
      r_ldr          <= '0;
      r_dirty_ship   <= 1'b1;
      r_dirty_planet <= 1'b1;
    end else begin
      // NOTE: non-blocking everywhere, so the later bmp_we assignment overrides the dirty clear.
      r_sync[0] <= IRQ_Vsync;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sync_q <= r_sync[SYNC_STAGES-1];
      r_rise   <= r_sync[SYNC_STAGES-1] & ~r_sync_q;

      for (int i = 0; i < 4; i++) begin
        r_pend[i] <= w_pend_nxt[i];
        r_snap[i] <= w_snap_nxt[i];
      end

      if (w_load) begin
        r_idx <= w_idx_nxt;
        r_ldr <= w_ldr_nxt;
        if (w_idx_nxt == IDX_SHIP0)   r_dirty_ship   <= 1'b0;
        if (w_idx_nxt == IDX_PLANET0) r_dirty_planet <= 1'b0;
      end

      if (bmp_we) begin
        if (bmp_sel) begin
          r_planet[bmp_row] <= bmp_data;
          r_dirty_planet    <= 1'b1;
        end else begin
          r_ship[bmp_row] <= bmp_data;
          r_dirty_ship    <= 1'b1;
        end
      end
    end
  end

  assign wren       = (r_state == S_STROBE);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign addr       = r_idx;
  assign ldr        = r_ldr;

endmodule

// File: tb/tb_vga_sprite_writer.sv
// Bench for vga_sprite_writer: a cycle-count reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vga_sprite_writer;
  localparam int S = 2;

  logic        clk_50_mhz = 1'b0;
  logic        rst = 1'b1;
  logic        IRQ_Vsync = 1'b0;
  logic [9:0]  ship_x = '0, ship_y = '0, planet_x = '0, planet_y = '0;
  logic        pos_valid = 1'b0, bmp_we = 1'b0, bmp_sel = 1'b0;
  logic [3:0]  bmp_row = '0;
  logic [15:0] bmp_data = '0;
  logic        wren, busy, frame_done;
  logic [5:0]  addr;
  logic [15:0] ldr;

  vga_sprite_writer #(.SYNC_STAGES(S)) dut (
    .clk_50_mhz(clk_50_mhz), .rst(rst), .IRQ_Vsync(IRQ_Vsync),
    .ship_x(ship_x), .ship_y(ship_y), .planet_x(planet_x), .planet_y(planet_y),
    .pos_valid(pos_valid), .bmp_we(bmp_we), .bmp_sel(bmp_sel), .bmp_row(bmp_row),
    .bmp_data(bmp_data), .wren(wren), .addr(addr), .ldr(ldr), .busy(busy),
    .frame_done(frame_done)
  );

  always #10 clk_50_mhz = ~clk_50_mhz;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: upload is a list of indices walked at 3 cycles per write.
  logic [15:0] m_ship [16];
  logic [15:0] m_planet [16];
  logic [9:0]  m_pend [4];
  logic [9:0]  m_snap [4];
  logic [9:0]  m_np [4];
  logic        m_dship, m_dplanet, m_active, m_done, m_rise, m_was_rst;
  logic [S+1:0] m_hist;
  int          m_t;
  logic [5:0]  m_idx;
  logic [15:0] m_ldr;

  function automatic logic [15:0] row_value(input logic [5:0] idx);
    if (idx >= 6'd32)      return {6'b0, m_snap[idx[1:0]]};
    else if (idx >= 6'd16) return m_planet[idx[3:0]];
    else                   return m_ship[idx[3:0]];
  endfunction

  always @(posedge clk_50_mhz) begin
    m_was_rst = rst;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin m_ship[i] = '0; m_planet[i] = '0; end
      for (int i = 0; i < 4; i++) begin m_pend[i] = '0; m_snap[i] = '0; end
      m_dship = 1'b1; m_dplanet = 1'b1; m_hist = '0;
      m_active = 1'b0; m_done = 1'b0; m_t = 0; m_idx = '0; m_ldr = '0;
    end else begin
      // Raw sample taken S+1 edges ago is the one whose rise starts an upload now.
      m_rise = m_hist[S] & ~m_hist[S+1];
      m_hist = {m_hist[S:0], IRQ_Vsync};
      m_np[0] = pos_valid ? ship_x   : m_pend[0];
      m_np[1] = pos_valid ? ship_y   : m_pend[1];
      m_np[2] = pos_valid ? planet_x : m_pend[2];
      m_np[3] = pos_valid ? planet_y : m_pend[3];
      if (!m_active) begin
        if (m_rise) begin
          for (int i = 0; i < 4; i++) m_snap[i] = m_np[i];
          m_active = 1'b1; m_t = 0;
          m_idx = m_dship ? 6'd0 : (m_dplanet ? 6'd16 : 6'd32);
          m_ldr = row_value(m_idx);
          if (m_idx == 6'd0)  m_dship = 1'b0;
          if (m_idx == 6'd16) m_dplanet = 1'b0;
        end
      end else if (m_done) begin
        m_active = 1'b0; m_done = 1'b0;
      end else begin
        m_t++;
        if (m_t % 3 == 0) begin
          if (m_idx == 6'd35) m_done = 1'b1;
          else begin
            m_idx = (m_idx == 6'd15) ? (m_dplanet ? 6'd16 : 6'd32) : m_idx + 6'd1;
            m_ldr = row_value(m_idx);
            if (m_idx == 6'd16) m_dplanet = 1'b0;
          end
        end
      end
      if (bmp_we) begin
        if (bmp_sel) begin m_planet[bmp_row] = bmp_data; m_dplanet = 1'b1; end
        else         begin m_ship[bmp_row]   = bmp_data; m_dship   = 1'b1; end
      end
      for (int i = 0; i < 4; i++) m_pend[i] = m_np[i];
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk_50_mhz) begin
    if (chk_en) begin
      check("busy", busy, m_active);
      check("wren", wren, m_active && !m_done && ((m_t % 3) == 1));
      check("frame_done", frame_done, m_done);
      if ((m_active && !m_done) || m_was_rst) begin
        check("addr", addr, m_idx);
        check("ldr", ldr, m_ldr);
      end
    end
  end

  typedef struct packed { logic [5:0] a; logic [15:0] d; } wr_t;
  wr_t wlog [$];
  int  fd_cnt = 0, busy_cnt = 0;
  int  log_base = 0, fd_base = 0, busy_base = 0;

  always @(negedge clk_50_mhz) begin
    if (wren === 1'b1) wlog.push_back({addr, ldr});
    if (frame_done === 1'b1) fd_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk_50_mhz);
    #2;
  endtask

  task automatic mark();
    log_base = wlog.size(); fd_base = fd_cnt; busy_base = busy_cnt;
  endtask

  task automatic wait_busy(input logic lvl, input int max, input string name);
    int n = 0;
    while (busy !== lvl && n < max) begin tick(); n++; end
    check(name, busy, lvl);
  endtask

  task automatic run_upload();
    IRQ_Vsync = 1'b1;
    wait_busy(1'b1, 20, "upload_start");
    wait_busy(1'b0, 200, "upload_end");
    IRQ_Vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic write_row(input logic sel, input logic [3:0] row, input logic [15:0] data);
    bmp_we = 1'b1; bmp_sel = sel; bmp_row = row; bmp_data = data;
    tick();
    bmp_we = 1'b0;
  endtask

  function automatic int seq_errors(input int n, input logic [5:0] first);
    int e = 0;
    for (int i = 0; i < n; i++)
      if (wlog[log_base+i].a != first + 6'(i)) e++;
    return e;
  endfunction

  initial begin
    int n;
    int edges;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_wren", wren, 1'b0);
    check("rst_addr", addr, 6'd0);
    check("rst_ldr", ldr, 16'd0);
    check("rst_fd", frame_done, 1'b0);
    rst = 1'b0;
    tick();

    // First upload after reset: both bitmaps plus positions.
    mark();
    IRQ_Vsync = 1'b1;
    edges = 0;
    while (busy !== 1'b1 && edges < 20) begin tick(); edges++; end
    check("latency", edges - 1, S + 1);
    wait_busy(1'b0, 200, "first_end");
    IRQ_Vsync = 1'b0;
    repeat (4) tick();
    check("first_nwrites", wlog.size() - log_base, 36);
    check("first_order", seq_errors(36, 6'h00), 0);
    check("first_busy", busy_cnt - busy_base, 109);
    check("first_fd", fd_cnt - fd_base, 1);

    // Positions only.
    ship_x = 10'h155; ship_y = 10'h0F0; planet_x = 10'h200; planet_y = 10'h010;
    pos_valid = 1'b1; tick(); pos_valid = 1'b0;
    mark();
    run_upload();
    check("pos_nwrites", wlog.size() - log_base, 4);
    check("pos_order", seq_errors(4, 6'h20), 0);
    check("pos_sx", wlog[log_base+0].d, 16'h0155);
    check("pos_sy", wlog[log_base+1].d, 16'h00F0);
    check("pos_px", wlog[log_base+2].d, 16'h0200);
    check("pos_py", wlog[log_base+3].d, 16'h0010);
    check("pos_busy", busy_cnt - busy_base, 13);

    // Planet only dirty.
    write_row(1'b1, 4'd3, 16'hA5A5);
    mark();
    run_upload();
    check("planet_nwrites", wlog.size() - log_base, 20);
    check("planet_order", seq_errors(20, 6'h10), 0);
    check("planet_row3", wlog[log_base+3].d, 16'hA5A5);

    // Retrigger while busy is dropped.
    write_row(1'b0, 4'd9, 16'h0909);
    mark();
    IRQ_Vsync = 1'b1;
    wait_busy(1'b1, 20, "retrig_start");
    repeat (4) tick();
    IRQ_Vsync = 1'b0;
    repeat (3) tick();
    IRQ_Vsync = 1'b1;
    wait_busy(1'b0, 200, "retrig_end");
    repeat (20) tick();
    IRQ_Vsync = 1'b0;
    repeat (4) tick();
    check("retrig_fd", fd_cnt - fd_base, 1);
    check("retrig_busy", busy_cnt - busy_base, 61);

    // Set wins: ship row 0 written on the edge row 0 enters SETUP.
    write_row(1'b0, 4'd5, 16'h1234);
    mark();
    IRQ_Vsync = 1'b1;
    repeat (S + 1) tick();
    write_row(1'b0, 4'd0, 16'hBEEF);
    wait_busy(1'b0, 200, "race_end");
    IRQ_Vsync = 1'b0;
    repeat (4) tick();
    check("race_first_addr", wlog[log_base].a, 6'h00);
    check("race_old_row0", wlog[log_base].d, 16'h0000);
    mark();
    run_upload();
    check("race_resend_n", wlog.size() - log_base, 20);
    check("race_new_row0", wlog[log_base].d, 16'hBEEF);
    check("race_row5", wlog[log_base+5].d, 16'h1234);

    // Reset during STROBE of 0x05.
    write_row(1'b0, 4'd7, 16'h7777);
    mark();
    IRQ_Vsync = 1'b1;
    n = 0;
    while (!(wren === 1'b1 && addr === 6'd5) && n < 100) begin tick(); n++; end
    check("reach_strobe5", {wren, addr}, {1'b1, 6'd5});
    rst = 1'b1; IRQ_Vsync = 1'b0;
    bmp_we = 1'b1; bmp_sel = 1'b0; bmp_row = 4'd2; bmp_data = 16'hFFFF;
    tick();
    check("abort_wren", wren, 1'b0);
    check("abort_busy", busy, 1'b0);
    bmp_we = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("abort_no_fd", fd_cnt - fd_base, 0);
    mark();
    run_upload();
    check("after_rst_n", wlog.size() - log_base, 36);
    check("after_rst_busy", busy_cnt - busy_base, 109);
    check("after_rst_row2", wlog[log_base+2].d, 16'h0000);
    check("after_rst_row7", wlog[log_base+7].d, 16'h0000);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      ship_x = 10'($urandom); ship_y = 10'($urandom);
      planet_x = 10'($urandom); planet_y = 10'($urandom);
      pos_valid = ($urandom_range(0, 7) == 0);
      bmp_we = ($urandom_range(0, 3) == 0);
      bmp_sel = 1'($urandom); bmp_row = 4'($urandom); bmp_data = 16'($urandom);
      if ($urandom_range(0, 29) == 0) IRQ_Vsync = ~IRQ_Vsync;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 699) == 0) rst = 1'b1;
      tick();
    end
    rst = 1'b0; pos_valid = 1'b0; bmp_we = 1'b0; IRQ_Vsync = 1'b0;
    wait_busy(1'b0, 300, "drain");
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sprite_writer.md
VGA_SPRITE_WRITER -- requirements
Module: vga_sprite_writer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of flops in the IRQ_Vsync synchronizer.
REQ-002 The block SHALL have port clk_50_mhz, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port IRQ_Vsync, input, 1 bit: frame interrupt from the display block, asynchronous to clk_50_mhz.
REQ-005 The block SHALL have ports ship_x, ship_y, planet_x and planet_y, each input, 10 bits: staged sprite positions.
REQ-006 The block SHALL have port pos_valid, input, 1 bit: latches the four staged positions into the pending registers.
REQ-007 The block SHALL have port bmp_we, input, 1 bit: write strobe for the shadow bitmap.
REQ-008 The block SHALL have port bmp_sel, input, 1 bit: bitmap select, 0 = ship, 1 = planet.
REQ-009 The block SHALL have port bmp_row, input, 4 bits: shadow bitmap row index.
REQ-010 The block SHALL have port bmp_data, input, 16 bits: shadow bitmap row data.
REQ-011 The block SHALL have port wren, output, 1 bit: display register write strobe; the display treats it as an edge.
REQ-012 The block SHALL have port addr, output, 6 bits: display register address.
REQ-013 The block SHALL have port ldr, output, 16 bits: display register data.
REQ-014 The block SHALL have port busy, output, 1 bit: high while an upload is in progress.
REQ-015 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse when an upload completes.

Function
REQ-016 Shadow storage SHALL consist of ship[0:15] and planet[0:15] (16-bit rows), the pending positions and the snapshot positions (10-bit each), and the flags dirty_ship and dirty_planet.
REQ-017 When bmp_we=1, the block SHALL write bmp_data into the selected row and set the matching dirty flag; this occurs in any state.
REQ-018 When pos_valid=1, the block SHALL load all four pending positions from the inputs; this occurs in any state.
REQ-019 IRQ_Vsync SHALL pass through a SYNC_STAGES-flop synchronizer, followed by a rising-edge detector.
REQ-020 The block SHALL have states IDLE, SETUP, STROBE, HOLD and DONE.
REQ-021 IDLE->SETUP SHALL occur on a detected rising edge; a rising edge detected while busy=1 SHALL be dropped, with no queuing.
REQ-022 On leaving IDLE, the block SHALL copy the pending positions into the snapshot; a pos_valid in that same cycle SHALL supply the new values to the snapshot.
REQ-023 The write index SHALL cover 0..35: 0-15 are ship rows (addr 0x00-0x0F), 16-31 are planet rows (addr 0x10-0x1F), and 32-35 are ship_x, ship_y, planet_x and planet_y (addr 0x20-0x23).
REQ-024 The start index SHALL be 0 if dirty_ship=1, else 16 if dirty_planet=1, else 32.
REQ-025 After index 15, the next index SHALL be 16 if dirty_planet=1, else 32.
REQ-026 The four position writes SHALL always be issued, because they clear IRQ_Vsync at the display.
REQ-027 A sprite's dirty flag SHALL clear in the cycle its row 0 enters SETUP; a bmp_we to that sprite in the same cycle SHALL leave the flag set (set wins).
REQ-028 Each register write SHALL take exactly 3 cycles:
- SETUP: addr and ldr driven, wren=0.
- STROBE: wren=1.
- HOLD: wren=0, with addr and ldr unchanged.
REQ-029 addr and ldr SHALL be stable from SETUP through HOLD of each write.
REQ-030 For position writes, ldr SHALL equal {6'b0, value}; for bitmap writes, ldr SHALL equal the row as it was at SETUP.
REQ-031 After HOLD of index 35, the block SHALL enter DONE; DONE SHALL assert frame_done=1 for 1 cycle and then return to IDLE.
REQ-032 busy SHALL be 1 in SETUP, STROBE, HOLD and DONE, and 0 in IDLE.
REQ-033 Upload length SHALL be 12 cycles with positions only, 60 cycles with one dirty bitmap, and 108 cycles with both dirty, in each case plus 1 DONE cycle.
REQ-034 Latency: the first SETUP SHALL occur SYNC_STAGES+1 cycles after the first clock edge at which raw IRQ_Vsync is sampled high.

Reset
REQ-035 While rst=1, the block SHALL force state=IDLE, wren=0, addr=0, ldr=0, busy=0 and frame_done=0.
REQ-036 While rst=1, the block SHALL set index=0, all shadow rows=0, pending and snapshot positions=0, synchronizer flops=0 and edge detector=0.
REQ-037 While rst=1, the block SHALL set dirty_ship=1 and dirty_planet=1, so the first upload after reset sends both bitmaps.
REQ-038 A reset mid-upload SHALL abort the upload, with wren=0 from the next edge; if the reset lands in STROBE, wren SHALL fall at that edge and no further strobe SHALL be issued.
REQ-039 bmp_we and pos_valid SHALL be ignored while rst=1.

Verification
REQ-040 First upload after reset: IRQ_Vsync rises -> 36 writes with addr 0x00..0x23 in order, each producing exactly one wren pulse of 1 cycle; busy stays high for 109 cycles; frame_done pulses once.
REQ-041 Positions only: ship_x=0x155, ship_y=0x0F0, planet_x=0x200, planet_y=0x010 with pos_valid, no dirty flags, IRQ_Vsync rises -> ldr shows 0x0155, 0x00F0, 0x0200 and 0x0010 at addr 0x20..0x23; frame_done arrives 13 cycles after the first SETUP.
REQ-042 Planet only dirty: bmp_we with sel=1, row=3, data=0xA5A5 -> the upload issues addr 0x10..0x1F then 0x20..0x23; addr 0x13 carries ldr=0xA5A5 and no 0x00-0x0F address appears.
REQ-043 Busy retrigger: IRQ_Vsync toggles high again mid-upload -> exactly one frame_done and no second upload until the next edge while idle.
REQ-044 Set-wins race: bmp_we to ship row 0 in the cycle row 0 enters SETUP -> dirty_ship=1 after the upload, and the next frame re-sends the ship rows with the new data.
REQ-045 Reset during STROBE of addr 0x05: wren=0 at the next edge, state is IDLE, busy=0, no frame_done occurs, and the next IRQ_Vsync triggers a full 36-write upload.
